renode_axi_read_arbiter: RTL and testbench

- Round-robin arbiter sharing one AXI read port (AR + R channels) between NumManagers requesting managers.
- Sits upstream of the Renode AXI subordinate, so several HDL masters can read through one Renode bus connection.
- Holds one outstanding burst at a time. The grant is locked from the AR handshake until the R beat with rlast completes.

---
 rtl/renode_axi_read_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_renode_axi_read_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/renode_axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// renode_axi_read_arbiter
//
// Round-robin arbiter that lets NumManagers AXI read managers share one AR/R
// port toward the Renode AXI subordinate. Only one burst is outstanding at a
// time. The grant is taken in IDLE, held through the AR handshake (ADDRESS),
// and released after the R beat carrying rlast completes (DATA).
//
// Ports:
//   aclk, areset          clock (rising edge) and asynchronous active-high reset
//   m_ar*                 per-manager AR channels, packed with manager i at slice i
//   m_rvalid / m_rready   per-manager R handshake
//   m_rid/rdata/rresp/rlast  R payload broadcast to every manager
//   s_ar*, s_r*           shared subordinate AR and R channels
//   grant_valid           high while a manager owns the port (ADDRESS or DATA)
//   grant_index           index of the current owner
//   rid_mismatch          (optional) sticky flag: an R beat returned an
//                         unexpected rid
//
// Optional feature macro: RENODE_AXI_READ_ARBITER_RID_CHECK_EN
//   When defined, arid is captured at the AR handshake and every R beat in
//   DATA is compared against it; a difference sets rid_mismatch until reset.
//   Routing is identical with or without the macro.
// -----------------------------------------------------------------------------
module renode_axi_read_arbiter #(
  parameter int NumManagers        = 2,
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8
) (
  input  logic                                      aclk,
  input  logic                                      areset,

  input  logic [NumManagers-1:0]                    m_arvalid,
  output logic [NumManagers-1:0]                    m_arready,
  input  logic [NumManagers*TransactionIdWidth-1:0] m_arid,
  input  logic [NumManagers*AddressWidth-1:0]       m_araddr,
  input  logic [NumManagers*8-1:0]                  m_arlen,
  input  logic [NumManagers*3-1:0]                  m_arsize,
  input  logic [NumManagers*2-1:0]                  m_arburst,

  output logic [NumManagers-1:0]                    m_rvalid,
  input  logic [NumManagers-1:0]                    m_rready,
  output logic [TransactionIdWidth-1:0]             m_rid,
  output logic [DataWidth-1:0]                      m_rdata,
  output logic [1:0]                                m_rresp,
  output logic                                      m_rlast,

  output logic                                      s_arvalid,
  input  logic                                      s_arready,
  output logic [TransactionIdWidth-1:0]             s_arid,
  output logic [AddressWidth-1:0]                   s_araddr,
  output logic [7:0]                                s_arlen,
  output logic [2:0]                                s_arsize,
  output logic [1:0]                                s_arburst,

  input  logic                                      s_rvalid,
  output logic                                      s_rready,
  input  logic [TransactionIdWidth-1:0]             s_rid,
  input  logic [DataWidth-1:0]                      s_rdata,
  input  logic [1:0]                                s_rresp,
  input  logic                                      s_rlast,

`ifdef RENODE_AXI_READ_ARBITER_RID_CHECK_EN
  output logic                                      rid_mismatch,
`endif
  output logic                                      grant_valid,
  output logic [$clog2(NumManagers)-1:0]            grant_index
);

  localparam int IndexWidth = $clog2(NumManagers);

  typedef enum logic [1:0] {
    IDLE,
    ADDRESS,
    DATA
  } state_t;

  state_t                state;
  logic [IndexWidth-1:0] rr_pointer;
  logic [IndexWidth-1:0] next_grant;
  logic [IndexWidth-1:0] candidate;
  logic                  any_request;
  logic                  ar_handshake;
  logic                  r_last_handshake;

  // Cyclic search starting at rr_pointer. Walking the offsets from the far end
  // back to zero lets the closest requester overwrite any farther one, so the
  // first requester at or after rr_pointer wins.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    next_grant  = rr_pointer;
    candidate   = '0;
    any_request = 1'b0;
    for (int offset = NumManagers - 1; offset >= 0; offset--) begin
      candidate = IndexWidth'((int'(rr_pointer) + offset) % NumManagers);
      if (m_arvalid[candidate]) begin
        next_grant  = candidate;
        any_request = 1'b1;
      end
    end
  end

  // Channel routing. Everything is gated by state, so IDLE forwards nothing,
  // an R beat arriving outside DATA sees s_rready=0 and stays with the
  // subordinate, and all payload outputs read zero while idle or in reset.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    s_arvalid = 1'b0;
    s_arid    = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_rready  = 1'b0;

    if (state == ADDRESS) begin
      // A granted manager that drops arvalid simply leaves s_arvalid low;
      // the grant is kept and no re-arbitration happens.
      s_arvalid              = m_arvalid[grant_index];
      s_arid                 = m_arid[grant_index*TransactionIdWidth +: TransactionIdWidth];
      s_araddr               = m_araddr[grant_index*AddressWidth +: AddressWidth];
      s_arlen                = m_arlen[grant_index*8 +: 8];
      s_arsize               = m_arsize[grant_index*3 +: 3];
      s_arburst              = m_arburst[grant_index*2 +: 2];
      m_arready[grant_index] = s_arready;
    end

    if (state == DATA) begin
      m_rvalid[grant_index] = s_rvalid;
      s_rready              = m_rready[grant_index];
      m_rid                 = s_rid;
      m_rdata               = s_rdata;
      m_rresp               = s_rresp;
      m_rlast               = s_rlast;
    end
  end

  assign ar_handshake     = s_arvalid && s_arready;
  // s_rready is only ever high in DATA, so this needs no extra state term.
  // The burst ends on rlast alone; arlen is never counted.
  assign r_last_handshake = s_rvalid && s_rready && s_rlast;

  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // block samples the pre-edge values, independent of statement order.
    if (areset) begin
      state       <= IDLE;
      grant_index <= '0;
      grant_valid <= 1'b0;
      rr_pointer  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_request) begin
            grant_index <= next_grant;
            grant_valid <= 1'b1;
            state       <= ADDRESS;
          end
        end
        ADDRESS: begin
          if (ar_handshake) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (r_last_handshake) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_pointer  <= (int'(grant_index) == NumManagers - 1) ? '0 : grant_index + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RENODE_AXI_READ_ARBITER_RID_CHECK_EN
  logic [TransactionIdWidth-1:0] expected_rid;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      expected_rid <= '0;
      rid_mismatch <= 1'b0;
    end else begin
      if (ar_handshake) begin
        expected_rid <= s_arid;
      end
      if (s_rvalid && s_rready && (s_rid != expected_rid)) begin
        rid_mismatch <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_renode_axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for renode_axi_read_arbiter (two managers).
// A table of single-manager bursts is applied in a loop, followed by
// hand-written sequences for round-robin ordering, blocking of a second
// manager during DATA, R backpressure, reset mid-burst and (with
// RENODE_AXI_READ_ARBITER_RID_CHECK_EN) the rid check. Expected AR requests
// and R beats are queued when stimulus is driven and popped when the DUT
// presents them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_renode_axi_read_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 8;

  logic             aclk = 1'b0;
  logic             areset;
  logic [NM-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM*IW-1:0] m_arid;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*8-1:0]  m_arlen;
  logic [NM*3-1:0]  m_arsize;
  logic [NM*2-1:0]  m_arburst;
  logic [IW-1:0]    m_rid;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast;
  logic             s_arvalid, s_arready;
  logic [IW-1:0]    s_arid;
  logic [AW-1:0]    s_araddr;
  logic [7:0]       s_arlen;
  logic [2:0]       s_arsize;
  logic [1:0]       s_arburst;
  logic             s_rvalid, s_rready;
  logic [IW-1:0]    s_rid;
  logic [DW-1:0]    s_rdata;
  logic [1:0]       s_rresp;
  logic             s_rlast;
  logic             grant_valid;
  logic [0:0]       grant_index;
`ifdef RENODE_AXI_READ_ARBITER_RID_CHECK_EN
  logic             rid_mismatch;
`endif

  renode_axi_read_arbiter #(
    .NumManagers(NM), .AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
`ifdef RENODE_AXI_READ_ARBITER_RID_CHECK_EN
    .rid_mismatch(rid_mismatch),
`endif
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            mgr;
    ar_t           ar;
    logic [DW-1:0] base;
    int            exp_grant;
    int            beats;
  } vec_t;

  ar_t           ar_q[$];
  beat_t         beat_q[$];
  vec_t          vecs[4];
  logic [IW-1:0] tb_rid;
  int            vectors_applied = 0;
  int            miscompares     = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic ar_t mk_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
    ar_t a;
    a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst;
    return a;
  endfunction

  // Moves to 1 ns after the next rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic request(input int mgr, input ar_t ar);
    m_arid[mgr*IW +: IW]   = ar.id;
    m_araddr[mgr*AW +: AW] = ar.addr;
    m_arlen[mgr*8 +: 8]    = ar.len;
    m_arsize[mgr*3 +: 3]   = ar.size;
    m_arburst[mgr*2 +: 2]  = ar.burst;
    m_arvalid[mgr]         = 1'b1;
    ar_q.push_back(ar);
  endtask

  // Acts as the subordinate AR side: waits (bounded) for s_arvalid, checks the
  // forwarded request against the scoreboard and completes the handshake.
  task automatic accept_ar(input int mgr);
    ar_t exp;
    int  waited = 0;
    s_arready = 1'b1;
    #1;
    while (!s_arvalid && waited < 20) begin
      step();
      #1;
      waited++;
    end
    if (!s_arvalid) begin
      check("ar_timeout", s_arvalid, 1);
      s_arready = 1'b0;
      return;
    end
    check("ar_grant_index", grant_index, mgr);
    check("ar_m_arready", m_arready, 1 << mgr);
    check("ar_queue_nonempty", ar_q.size() != 0, 1);
    if (ar_q.size() != 0) begin
      exp = ar_q.pop_front();
      check("ar_arid", s_arid, exp.id);
      check("ar_araddr", s_araddr, exp.addr);
      check("ar_arlen", s_arlen, exp.len);
      check("ar_arsize", s_arsize, exp.size);
      check("ar_arburst", s_arburst, exp.burst);
    end
    step();
    m_arvalid[mgr] = 1'b0;
    s_arready      = 1'b0;
  endtask

  task automatic pop_beat();
    beat_t e;
    if (beat_q.size() == 0) begin
      check("beat_queue_nonempty", beat_q.size(), 1);
      return;
    end
    e = beat_q.pop_front();
    check("beat_rdata", m_rdata, e.data);
    check("beat_rlast", m_rlast, e.last);
    check("beat_rid", m_rid, tb_rid);
  endtask

  // Subordinate returns n beats with no backpressure; with_last=0 leaves the
  // burst open (no rlast).
  task automatic send_beats(input int mgr, input int n, input logic [DW-1:0] base,
                            input bit with_last);
    beat_t b_exp;
    for (int b = 0; b < n; b++) begin
      s_rvalid   = 1'b1;
      s_rdata    = base + DW'(b);
      s_rid      = tb_rid;
      s_rresp    = 2'b00;
      s_rlast    = with_last && (b == n - 1);
      b_exp.data = s_rdata;
      b_exp.last = s_rlast;
      beat_q.push_back(b_exp);
      #1;
      check("r_m_rvalid", m_rvalid, 1 << mgr);
      check("r_s_rready", s_rready, m_rready[mgr]);
      check("r_m_arready_blocked", m_arready, 0);
      check("r_grant_valid", grant_valid, 1);
      if (m_rvalid[mgr] && m_rready[mgr]) pop_beat();
      step();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    if (with_last) begin
      #1;
      check("end_grant_valid", grant_valid, 0);
      check("end_beat_q_empty", beat_q.size(), 0);
    end
  endtask

  task automatic run_backpressure();
    bit [3:0] ready_pattern;
    beat_t    b_exp;
    int       b;
    int       pushed;
    bit       hs;
    ready_pattern = 4'b1001;  // cycle 0..3: 1,0,0,1
    b      = 0;
    pushed = -1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      m_rready[0] = ready_pattern[cyc];
      s_rvalid    = 1'b1;
      s_rdata     = DW'('hD0 + b);
      s_rid       = tb_rid;
      s_rlast     = (b == 1);
      if (pushed != b) begin
        b_exp.data = s_rdata;
        b_exp.last = s_rlast;
        beat_q.push_back(b_exp);
        pushed = b;
      end
      #1;
      check("bp_s_rready", s_rready, ready_pattern[cyc]);
      check("bp_m_rvalid", m_rvalid, 2'b01);
      check("bp_held_rdata", m_rdata, DW'('hD0 + b));
      hs = s_rready;
      if (m_rvalid[0] && m_rready[0]) pop_beat();
      step();
      if (hs) b++;
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = '1;
    #1;
    check("bp_beats_delivered", b, 2);
    check("bp_grant_released", grant_valid, 0);
    check("bp_beat_q_empty", beat_q.size(), 0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{mgr: 0, ar: mk_ar(8'h11, 32'h0000_0100, 8'd3, 3'd2, 2'd1),
                base: 32'hA000_0000, exp_grant: 0, beats: 4};
    vecs[1] = '{mgr: 1, ar: mk_ar(8'h22, 32'h0000_2000, 8'd0, 3'd2, 2'd1),
                base: 32'hB000_0000, exp_grant: 1, beats: 1};
    vecs[2] = '{mgr: 1, ar: mk_ar(8'h05, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'd0),
                base: 32'hC000_0000, exp_grant: 1, beats: 2};
    vecs[3] = '{mgr: 0, ar: mk_ar(8'hFF, 32'h0000_0000, 8'd7, 3'd1, 2'd2),
                base: 32'hD000_0000, exp_grant: 0, beats: 8};

    // Reset with live requests and a pending R beat: nothing may leak out.
    areset    = 1'b1;
    m_arvalid = 2'b11;
    m_rready  = '1;
    m_arid    = '1;
    m_araddr  = '1;
    m_arlen   = '1;
    m_arsize  = '1;
    m_arburst = '1;
    s_arready = 1'b1;
    s_rvalid  = 1'b1;
    s_rid     = '1;
    s_rdata   = 32'hDEAD_BEEF;
    s_rresp   = 2'b11;
    s_rlast   = 1'b1;
    tb_rid    = '0;
    step();
    step();
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_index", grant_index, 0);
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_m_arready", m_arready, 0);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_s_rready", s_rready, 0);
    check("rst_s_araddr", s_araddr, 0);
    check("rst_m_rdata", m_rdata, 0);
`ifdef RENODE_AXI_READ_ARBITER_RID_CHECK_EN
    check("rst_rid_mismatch", rid_mismatch, 0);
`endif
    m_arvalid = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    areset    = 1'b0;
    step();

    // Table of single-manager bursts; also shows re-grant after one IDLE cycle.
    for (int i = 0; i < 4; i++) begin
      tb_rid = vecs[i].ar.id;
      request(vecs[i].mgr, vecs[i].ar);
      #1;
      check("idle_no_forward", s_arvalid, 0);
      step();
      #1;
      check("ar_latency_s_arvalid", s_arvalid, 1);
      check("addr_grant_valid", grant_valid, 1);
      check("addr_grant_index", grant_index, vecs[i].exp_grant);
      check("addr_m_rvalid_quiet", m_rvalid, 0);
      accept_ar(vecs[i].mgr);
      send_beats(vecs[i].mgr, vecs[i].beats, vecs[i].base, 1'b1);
`ifdef RENODE_AXI_READ_ARBITER_RID_CHECK_EN
      check("table_rid_clean", rid_mismatch, 0);
`endif
    end

    // Simultaneous requests after reset: 0, then 1, then 0 again; manager 1
    // waits with m_arready low through manager 0's DATA phase.
    do_reset();
    request(0, mk_ar(8'h01, 32'h0000_0400, 8'd1, 3'd2, 2'd1));
    request(1, mk_ar(8'h05, 32'h0000_0800, 8'd0, 3'd2, 2'd1));
    step();
    #1;
    check("rr_first_grant", grant_index, 0);
    accept_ar(0);
    request(0, mk_ar(8'h09, 32'h0000_0C00, 8'd0, 3'd2, 2'd1));
    tb_rid = 8'h01;
    send_beats(0, 2, 32'h0000_00A0, 1'b1);
    accept_ar(1);
    tb_rid = 8'h05;
    send_beats(1, 1, 32'h0000_00B0, 1'b1);
    accept_ar(0);
    tb_rid = 8'h09;
    send_beats(0, 1, 32'h0000_00C0, 1'b1);

    // R backpressure on manager 0: rready 1,0,0,1 across a two-beat burst.
    tb_rid = 8'h07;
    request(0, mk_ar(8'h07, 32'h0000_0100, 8'd1, 3'd2, 2'd1));
    accept_ar(0);
    run_backpressure();

    // Reset in DATA after beat 2 of 4 (rr_pointer is 1 beforehand).
    tb_rid = 8'h02;
    request(1, mk_ar(8'h02, 32'h0000_3000, 8'd3, 3'd2, 2'd1));
    accept_ar(1);
    send_beats(1, 2, 32'h0000_00E0, 1'b0);
    s_rvalid = 1'b1;
    s_rdata  = 32'h0000_00E2;
    areset   = 1'b1;
    #1;
    check("mid_rst_s_rready", s_rready, 0);
    check("mid_rst_m_rvalid", m_rvalid, 0);
    check("mid_rst_grant_valid", grant_valid, 0);
    check("mid_rst_m_rdata", m_rdata, 0);
    step();
    areset   = 1'b0;
    s_rvalid = 1'b0;
    request(0, mk_ar(8'h1A, 32'h0000_0500, 8'd0, 3'd2, 2'd1));
    request(1, mk_ar(8'h1B, 32'h0000_0600, 8'd0, 3'd2, 2'd1));
    step();
    #1;
    check("post_reset_lowest_grant", grant_index, 0);
    accept_ar(0);
    tb_rid = 8'h1A;
    send_beats(0, 1, 32'h0000_00F0, 1'b1);
    accept_ar(1);
    tb_rid = 8'h1B;
    send_beats(1, 1, 32'h0000_00F8, 1'b1);

`ifdef RENODE_AXI_READ_ARBITER_RID_CHECK_EN
    // arid 'h3 answered with rid 'h4 sets the flag, which then stays set.
    check("rid_clean_before", rid_mismatch, 0);
    request(0, mk_ar(8'h03, 32'h0000_0700, 8'd1, 3'd2, 2'd1));
    accept_ar(0);
    tb_rid = 8'h04;
    send_beats(0, 1, 32'h0000_0010, 1'b0);
    check("rid_mismatch_set", rid_mismatch, 1);
    tb_rid = 8'h03;
    send_beats(0, 1, 32'h0000_0011, 1'b1);
    check("rid_mismatch_sticky", rid_mismatch, 1);
`endif

    check("ar_queue_drained", ar_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
